spw_ulight_nofifo_tx_pio: RTL and testbench
===========================================

Name: spw_ulight_nofifo_tx_pio

Overview:
- Avalon-MM write-side companion to the 14-bit link-status monitor PIO. The monitor lets the Nios read link state; this block lets the Nios drive the link.
- Nios writes a control word and single SpaceWire TX characters.
- Each character is held in a one-deep holding register and handed to the SpW ulight core over a valid/ready handshake.
- A sticky overflow flag and a sent-character counter are readable.
- Sits between the Avalon interconnect and the SpW core TX/control inputs, in the no-FIFO system.

Parameters:
- CTRL_W, 14, width of the control output bus (matches the monitor input width).
- DATA_W, 9, TX character width: bit 8 = control flag, bits 7:0 = data/EOP code.
- CNT_W, 16, width of the sent-character counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset. Synchronous, active-low; sampled on the rising edge of clk.
- address  in  2  Avalon word address.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data. Registered, zero-extended.
- ctrl_out  out  CTRL_W  control word to the SpW core (link_start, autostart, link_disable, tx clock divider, ...).
- tx_data  out  DATA_W  character to transmit.
- tx_valid  out  1  holding register valid toward the core.
- tx_ready  in  1  core accepts the character this cycle.

Behaviour:
- Reset (reset_n=0 at a clk edge) clears all state: readdata=0, ctrl_out=0, tx_data=0, tx_valid=0, pending=0, overflow=0, enable=0, count=0.
- Reset mid-handshake drops the pending character. It is not counted.
- Register map:
  - addr0 DATA: write loads writedata[DATA_W-1:0] into the holding register and sets pending. Read returns the holding register.
  - addr1 STATUS: read returns {29'b0, tx_ready, overflow, pending}. A write with writedata[1]=1 clears overflow; other bits are ignored.
  - addr2 CTRL: write loads ctrl_out <= writedata[CTRL_W-1:0] and enable <= writedata[31]. Read returns {enable, zeros, ctrl_out}.
  - addr3 COUNT: read returns count zero-extended. Any write clears count.
- readdata is updated every clk from the addressed register, with no read strobe (same style as the monitor PIO). Read latency is 1 cycle.
- tx_valid = pending & enable, combinational from registers. tx_data = holding register.
- Transfer completes in any cycle where tx_valid & tx_ready. On the next edge: pending <= 0 and count <= count+1.
- Count wraps from 2^CNT_W-1 to 0 with no flag.
- If the core holds tx_ready low, tx_valid stays high and tx_data stays stable until accepted. Deasserting enable withdraws tx_valid but keeps pending.
- DATA write while pending=1 and no transfer that cycle: the write is dropped, the holding register is unchanged, and overflow <= 1 (sticky).
- DATA write in the same cycle as a completing transfer: the new data is loaded, pending stays 1, and overflow is not set.
- Overflow set and clear in the same cycle: set wins.
- COUNT clear write in the same cycle as a transfer: clear wins, count=0.
- The state machine is implicit: IDLE (pending=0) -> HOLD (pending=1) on a DATA write. HOLD -> IDLE on transfer, unless refilled in the same cycle.
- Writes to unmapped bits have no effect. No wait states; waitrequest is not used.

Decomposition:
- Shared package (spw_ulight_pio_pkg): address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_COUNT=3; STATUS bit indices; CTRL enable bit index 31; default widths.
- One natural sub-module: spw_ulight_tx_hold. It contains the holding register, the pending/overflow logic and the handshake, with load/clear_ovf inputs and pending/overflow/fire outputs.
- The counter and the Avalon decode stay in the top level.

Test Plan:
- Reset: drive reset_n=0 for 2 clk with write=1 and tx_ready=1 -> all outputs 0. A read of addr1 one cycle after release returns 0.
- Basic send:
  - Write addr2 = 0x8000_0005 -> ctrl_out=0x0005, enable=1.
  - Write addr0 = 0x1A5 with tx_ready=0 for 3 cycles -> tx_valid=1 and tx_data=0x1A5, stable.
  - Raise tx_ready -> tx_valid=0 next cycle. Read addr3 = 1.
- Overflow: with tx_ready=0 and enable=1, write addr0=0x011 then addr0=0x022 -> tx_data stays 0x011 and addr1 reads 0x3.
- Overflow clear: write addr1=0x2 -> addr1 reads 0x1.
- Same-cycle refill: while tx_valid & tx_ready, write addr0=0x033 -> pending stays 1, tx_data=0x033 next cycle, overflow=0, count increments by 1.
- Enable gating: pending=1 with enable=0 and tx_ready=1 for 5 cycles -> tx_valid=0 and count unchanged. Set enable=1 -> transfer completes in 1 cycle.
- Counter wrap/clear: preload 0xFFFF transfers (or force) and send 1 more -> count=0x0000. A COUNT write coinciding with a transfer -> count=0.

Source files
------------

// File: rtl/spw_ulight_nofifo_tx_pio_pkg.sv
// Shared constants for the no-FIFO SpaceWire TX PIO: register map, bit indices,
// default widths and the holding-register state type.
package spw_ulight_pio_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int STAT_PENDING  = 0;
    localparam int STAT_OVERFLOW = 1;
    localparam int STAT_TX_READY = 2;
    localparam int CTRL_EN_BIT   = 31;

    localparam int BUS_W      = 32;
    localparam int DEF_CTRL_W = 14;
    localparam int DEF_DATA_W = 9;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        HOLD_IDLE = 1'b0,
        HOLD_FULL = 1'b1
    } hold_state_t;

    function automatic logic [BUS_W-1:0] status_word(input logic tx_ready,
                                                     input logic overflow,
                                                     input logic pending);
        logic [BUS_W-1:0] w;
        w                = '0;
        w[STAT_TX_READY] = tx_ready;
        w[STAT_OVERFLOW] = overflow;
        w[STAT_PENDING]  = pending;
        return w;
    endfunction

endpackage

// File: rtl/spw_ulight_nofifo_tx_pio_if.sv
// Avalon-MM slave bus plus the TX character handshake and control word toward the SpW core.
interface spw_ulight_nofifo_tx_pio_if import spw_ulight_pio_pkg::*; #(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [1:0]        address;
    logic              write;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output address, write, writedata, tx_ready,
        input  readdata, ctrl_out, tx_data, tx_valid
    );

    modport slave (
        input  address, write, writedata, tx_ready,
        output readdata, ctrl_out, tx_data, tx_valid
    );
endinterface

// File: rtl/spw_ulight_nofifo_tx_pio_tx_hold.sv
// One-deep TX holding register with sticky overflow and valid/ready hand-off.
module spw_ulight_tx_hold import spw_ulight_pio_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              clear_ovf,
    input  logic              enable,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              pending,
    output logic              overflow,
    output logic              fire
);

    hold_state_t       state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              ovf_reg, ovf_next;

    assign pending  = (state_reg == HOLD_FULL);
    assign tx_valid = pending & enable;
    assign fire     = tx_valid & tx_ready;
    assign tx_data  = data_reg;
    assign overflow = ovf_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= HOLD_IDLE;
            data_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Clear is applied first so a coincident overflow set overrides it.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        ovf_next   = ovf_reg;
        if (clear_ovf) begin
            ovf_next = 1'b0;
        end
        case (state_reg)
            HOLD_IDLE: begin
                if (load) begin
                    state_next = HOLD_FULL;
                    data_next  = load_data;
                end
            end
            HOLD_FULL: begin
                if (load && fire) begin
                    data_next = load_data;
                end else if (load) begin
                    ovf_next = 1'b1;
                end else if (fire) begin
                    state_next = HOLD_IDLE;
                end
            end
            default: state_next = HOLD_IDLE;
        endcase
    end

endmodule

// File: rtl/spw_ulight_nofifo_tx_pio.sv
// Avalon-MM write-side PIO for the no-FIFO SpW ulight system: control word,
// single-character TX with overflow flag, and a sent-character counter.
module spw_ulight_nofifo_tx_pio import spw_ulight_pio_pkg::*; #(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset_n,
    spw_ulight_nofifo_tx_pio_if.slave   pio
);

    logic [CTRL_W-1:0] ctrl_reg;
    logic              enable_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [BUS_W-1:0]  readdata_reg, readdata_next;

    logic wr_data, wr_status, wr_ctrl, wr_count;
    logic clear_ovf;
    logic pending, overflow, fire;
    logic unused_bits;

    assign wr_data   = pio.write && (pio.address == ADDR_DATA);
    assign wr_status = pio.write && (pio.address == ADDR_STATUS);
    assign wr_ctrl   = pio.write && (pio.address == ADDR_CTRL);
    assign wr_count  = pio.write && (pio.address == ADDR_COUNT);
    assign clear_ovf = wr_status && pio.writedata[STAT_OVERFLOW];

    assign unused_bits = &{1'b0, pio.writedata};

    spw_ulight_tx_hold #(.DATA_W(DATA_W)) u_hold (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (wr_data),
        .load_data (pio.writedata[DATA_W-1:0]),
        .clear_ovf (clear_ovf),
        .enable    (enable_reg),
        .tx_ready  (pio.tx_ready),
        .tx_data   (pio.tx_data),
        .tx_valid  (pio.tx_valid),
        .pending   (pending),
        .overflow  (overflow),
        .fire      (fire)
    );

    // A COUNT write overrides an increment from a same-cycle transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_reg     <= '0;
            enable_reg   <= 1'b0;
            count_reg    <= '0;
            readdata_reg <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_reg   <= pio.writedata[CTRL_W-1:0];
                enable_reg <= pio.writedata[CTRL_EN_BIT];
            end
            if (wr_count) begin
                count_reg <= '0;
            end else if (fire) begin
                count_reg <= count_reg + 1'b1;
            end
            readdata_reg <= readdata_next;
        end
    end

    always_comb begin
        readdata_next = '0;
        case (pio.address)
            ADDR_DATA:   readdata_next = {{(BUS_W-DATA_W){1'b0}}, pio.tx_data};
            ADDR_STATUS: readdata_next = status_word(pio.tx_ready, overflow, pending);
            ADDR_CTRL:   readdata_next = {enable_reg, {(BUS_W-1-CTRL_W){1'b0}}, ctrl_reg};
            ADDR_COUNT:  readdata_next = {{(BUS_W-CNT_W){1'b0}}, count_reg};
            default:     readdata_next = '0;
        endcase
    end

    assign pio.readdata = readdata_reg;
    assign pio.ctrl_out = ctrl_reg;

endmodule

// File: tb/tb_spw_ulight_nofifo_tx_pio.sv
// Self-checking bench: directed register-map scenarios plus randomized traffic
// compared every cycle against a behavioural register-map model.
module tb_spw_ulight_nofifo_tx_pio;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    bit   chk_en;

    spw_ulight_nofifo_tx_pio_if #(.CTRL_W(14), .DATA_W(9)) bus ();

    spw_ulight_nofifo_tx_pio #(.CTRL_W(14), .DATA_W(9), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pio     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the visible register state.
    logic [8:0]  m_hold;
    logic        m_pend, m_ovf, m_en;
    logic [13:0] m_ctrl;
    logic [15:0] m_cnt;
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h time=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic        f;
        logic [31:0] wd;
        wd = bus.writedata;
        if (!reset_n) begin
            m_hold = '0; m_pend = 0; m_ovf = 0; m_en = 0;
            m_ctrl = '0; m_cnt = '0; m_rd = '0;
        end else begin
            f = m_pend & m_en & bus.tx_ready;
            case (bus.address)
                2'd0: m_rd = {23'd0, m_hold};
                2'd1: m_rd = {29'd0, bus.tx_ready, m_ovf, m_pend};
                2'd2: m_rd = {m_en, 17'd0, m_ctrl};
                default: m_rd = {16'd0, m_cnt};
            endcase
            if (f) m_pend = 0;
            if (bus.write && bus.address == 2'd1 && wd[1]) m_ovf = 0;
            if (bus.write && bus.address == 2'd0) begin
                if (m_pend) m_ovf = 1;
                else begin
                    m_hold = wd[8:0];
                    m_pend = 1;
                end
            end
            if (bus.write && bus.address == 2'd2) begin
                m_ctrl = wd[13:0];
                m_en   = wd[31];
            end
            if (bus.write && bus.address == 2'd3) m_cnt = 0;
            else if (f) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic cyc(input logic [1:0] a, input logic w, input logic [31:0] d, input logic rdy);
        bus.address   = a;
        bus.write     = w;
        bus.writedata = d;
        bus.tx_ready  = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("readdata", bus.readdata, m_rd);
            chk("ctrl_out", {18'd0, bus.ctrl_out}, {18'd0, m_ctrl});
            chk("tx_data", {23'd0, bus.tx_data}, {23'd0, m_hold});
            chk("tx_valid", {31'd0, bus.tx_valid}, {31'd0, m_pend & m_en});
        end
    end

    initial begin
        logic [1:0]  a;
        logic        w, r;
        logic [31:0] d;
        checks = 0; failures = 0; chk_en = 0;
        reset_n = 1'b0;

        // Reset with write and tx_ready active
        cyc(2'd0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        chk_en = 1;
        cyc(2'd2, 1'b1, 32'hFFFF_FFFF, 1'b1);
        chk("rst_readdata", bus.readdata, 32'h0);
        chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'h0);
        chk("rst_ctrl", {18'd0, bus.ctrl_out}, 32'h0);
        reset_n = 1'b1;
        cyc(2'd1, 1'b0, 32'h0, 1'b0);
        chk("rst_status_read", bus.readdata, 32'h0);

        // Basic send
        cyc(2'd2, 1'b1, 32'h8000_0005, 1'b0);
        chk("ctrl_write", {18'd0, bus.ctrl_out}, 32'h5);
        cyc(2'd2, 1'b0, 32'h0, 1'b0);
        chk("ctrl_read", bus.readdata, 32'h8000_0005);
        cyc(2'd0, 1'b1, 32'h1A5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(2'd0, 1'b0, 32'h0, 1'b0);
            chk("hold_valid", {31'd0, bus.tx_valid}, 32'h1);
            chk("hold_data", {23'd0, bus.tx_data}, 32'h1A5);
        end
        cyc(2'd3, 1'b0, 32'h0, 1'b1);
        chk("sent_valid_low", {31'd0, bus.tx_valid}, 32'h0);
        cyc(2'd3, 1'b0, 32'h0, 1'b0);
        chk("count_one", bus.readdata, 32'h1);

        // Overflow and clear
        cyc(2'd0, 1'b1, 32'h011, 1'b0);
        cyc(2'd0, 1'b1, 32'h022, 1'b0);
        chk("ovf_data_kept", {23'd0, bus.tx_data}, 32'h011);
        cyc(2'd1, 1'b0, 32'h0, 1'b0);
        chk("ovf_status", bus.readdata, 32'h3);
        cyc(2'd1, 1'b1, 32'h2, 1'b0);
        cyc(2'd1, 1'b0, 32'h0, 1'b0);
        chk("ovf_cleared", bus.readdata, 32'h1);

        // Same-cycle refill
        cyc(2'd0, 1'b1, 32'h033, 1'b1);
        chk("refill_data", {23'd0, bus.tx_data}, 32'h033);
        chk("refill_valid", {31'd0, bus.tx_valid}, 32'h1);
        cyc(2'd1, 1'b0, 32'h0, 1'b0);
        chk("refill_status", bus.readdata, 32'h1);
        cyc(2'd3, 1'b0, 32'h0, 1'b0);
        chk("refill_count", bus.readdata, 32'h2);
        cyc(2'd3, 1'b0, 32'h0, 1'b1);

        // Enable gating
        cyc(2'd0, 1'b1, 32'h044, 1'b0);
        cyc(2'd2, 1'b1, 32'h0000_0005, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(2'd3, 1'b0, 32'h0, 1'b1);
            chk("gated_valid", {31'd0, bus.tx_valid}, 32'h0);
            chk("gated_count", bus.readdata, 32'h3);
        end
        cyc(2'd2, 1'b1, 32'h8000_0005, 1'b1);
        chk("enabled_valid", {31'd0, bus.tx_valid}, 32'h1);
        cyc(2'd3, 1'b0, 32'h0, 1'b1);
        chk("enabled_sent", {31'd0, bus.tx_valid}, 32'h0);
        cyc(2'd3, 1'b0, 32'h0, 1'b0);
        chk("enabled_count", bus.readdata, 32'h4);

        // COUNT clear coinciding with a transfer
        cyc(2'd0, 1'b1, 32'h055, 1'b0);
        cyc(2'd3, 1'b1, 32'h0, 1'b1);
        cyc(2'd3, 1'b0, 32'h0, 1'b0);
        chk("clear_wins", bus.readdata, 32'h0);

        // Randomized traffic including occasional resets
        for (int i = 0; i < 3000; i++) begin
            a = 2'($urandom_range(0, 3));
            w = ($urandom_range(0, 2) != 0);
            d = $urandom;
            r = 1'($urandom_range(0, 1));
            if (a == 2'd2) d[31] = ($urandom_range(0, 3) != 0);
            if (a == 2'd3) w = ($urandom_range(0, 7) == 0);
            reset_n = ($urandom_range(0, 299) != 0);
            cyc(a, w, d, r);
        end
        reset_n = 1'b1;

        // Counter wrap: 0xFFFF transfers then one more
        cyc(2'd2, 1'b1, 32'h8000_0000, 1'b1);
        cyc(2'd3, 1'b1, 32'h0, 1'b1);
        cyc(2'd3, 1'b0, 32'h0, 1'b0);
        chk("wrap_start", bus.readdata, 32'h0);
        for (int i = 0; i < 65536; i++) begin
            cyc(2'd0, 1'b1, 32'(i & 32'h1FF), 1'b1);
        end
        cyc(2'd3, 1'b0, 32'h0, 1'b0);
        chk("count_ffff", bus.readdata, 32'hFFFF);
        cyc(2'd3, 1'b0, 32'h0, 1'b1);
        cyc(2'd3, 1'b0, 32'h0, 1'b0);
        chk("count_wrap", bus.readdata, 32'h0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
